// File: rtl/maze_player_ctrl.sv
// maze_player_ctrl: player position, lives and game-state controller for the maze game
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   tick                          movement pacing pulse, one step per tick in PLAY
//   start                         begins or restarts a game from IDLE, WIN or OVER
//   dir[3:0]                      {up,down,left,right} buttons, up has highest priority
//   startblk/tpblks/lavablks/goalblk  region flags decoded from the position outputs
//   xFlr, yFlr / xCeil, yCeil     player box top-left corner / bottom-right (+16)
//   lives, state                  remaining lives, FSM encoding
//   win, gameover, frozen         decoded from the current state
module maze_player_ctrl #(
   parameter int LIVES_INIT = 3,
   parameter int STEP       = 2,
   parameter int DEAD_TICKS = 32
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tick,
   input  logic       start,
   input  logic [3:0] dir,
   input  logic       startblk,
   input  logic       tpblks,
   input  logic       lavablks,
   input  logic       goalblk,
   output logic [9:0] xFlr,
   output logic [9:0] yFlr,
   output logic [9:0] xCeil,
   output logic [9:0] yCeil,
   output logic [1:0] lives,
   output logic [2:0] state,
   output logic       win,
   output logic       gameover,
   output logic       frozen
);
   typedef enum logic [2:0] {IDLE = 3'd0, PLAY = 3'd1, TELEPORT = 3'd2, DEAD = 3'd3, WIN = 3'd4, OVER = 3'd5} st_t;
   localparam int CW = DEAD_TICKS > 1 ? $clog2(DEAD_TICKS) : 1;
   localparam logic [9:0] X0 = 10'd8;
   localparam logic [9:0] Y0 = 10'd7;
   localparam logic [1:0] LV0 = 2'(LIVES_INIT);
   localparam logic [10:0] S = 11'(STEP);
   st_t st, st_n;
   logic [9:0] x, y, x_n, y_n;
   logic [1:0] lv, lv_n;
   logic armed, armed_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [10:0] xw, yw;
   logic [9:0] up_y, dn_y, lf_x, rt_x, dst_x, dst_y;
   logic in_a, in_b, in_c, in_d;
   logic unused;
   // the start-cell flag carries no behaviour of its own here
   assign unused = startblk;
   assign xw = {1'b0, x};
   assign yw = {1'b0, y};
   // saturating steps: computed one bit wider so the bound test cannot wrap
   assign up_y = yw >= S ? 10'(yw - S) : 10'd0;
   assign dn_y = yw + S > 11'd464 ? 10'd464 : 10'(yw + S);
   assign lf_x = xw >= S ? 10'(xw - S) : 10'd0;
   assign rt_x = xw + S > 11'd624 ? 10'd624 : 10'(xw + S);
   // source pad is identified by column only; destination is the next pad of the ring A->B->C->D->A
   assign in_a = x >= 10'd224 && x < 10'd256;
   assign in_b = x >= 10'd416 && x < 10'd448;
   assign in_c = x < 10'd32;
   assign in_d = x >= 10'd288 && x < 10'd320;
   assign dst_x = in_a ? 10'd424 : in_b ? 10'd8 : in_c ? 10'd296 : in_d ? 10'd232 : x;
   assign dst_y = in_a ? 10'd97 : in_b ? 10'd457 : in_c ? 10'd247 : in_d ? 10'd157 : y;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st    <= IDLE;
         x     <= X0;
         y     <= Y0;
         lv    <= LV0;
         armed <= 1'b1;
         cnt   <= '0;
      end else begin
         st    <= st_n;
         x     <= x_n;
         y     <= y_n;
         lv    <= lv_n;
         armed <= armed_n;
         cnt   <= cnt_n;
      end
   end
   always_comb begin
      st_n    = st;
      x_n     = x;
      y_n     = y;
      lv_n    = lv;
      armed_n = armed;
      cnt_n   = cnt;
      case (st)
         IDLE, WIN, OVER: begin
            if (start) begin
               st_n    = PLAY;
               x_n     = X0;
               y_n     = Y0;
               lv_n    = LV0;
               armed_n = 1'b1;
               cnt_n   = '0;
            end
         end
         PLAY: begin
            // leaving every pad re-arms teleporting; region flags outrank movement
            if (!tpblks) armed_n = 1'b1;
            if (goalblk) st_n = WIN;
            else if (lavablks) begin
               lv_n  = lv - 2'd1;
               st_n  = lv == 2'd1 ? OVER : DEAD;
               cnt_n = '0;
            end else if (tpblks && armed) st_n = TELEPORT;
            else if (tick) begin
               if (dir[3]) y_n = up_y;
               else if (dir[2]) y_n = dn_y;
               else if (dir[1]) x_n = lf_x;
               else if (dir[0]) x_n = rt_x;
            end
         end
         TELEPORT: begin
            st_n    = PLAY;
            x_n     = dst_x;
            y_n     = dst_y;
            armed_n = 1'b0;
         end
         DEAD: begin
            if (tick) begin
               if (cnt == CW'(DEAD_TICKS - 1)) begin
                  st_n    = PLAY;
                  x_n     = X0;
                  y_n     = Y0;
                  armed_n = 1'b1;
                  cnt_n   = '0;
               end else cnt_n = cnt + CW'(1);
            end
         end
         default: st_n = IDLE;
      endcase
   end
   assign xFlr     = x;
   assign yFlr     = y;
   assign xCeil    = x + 10'd16;
   assign yCeil    = y + 10'd16;
   assign lives    = lv;
   assign state    = st;
   assign win      = st == WIN;
   assign gameover = st == OVER;
   assign frozen   = st == DEAD;
endmodule

// File: tb/tb_maze_player_ctrl.sv
// tb_maze_player_ctrl: randomized and directed scoreboard bench for maze_player_ctrl
module tb_maze_player_ctrl;
   localparam int M_IDLE = 0, M_PLAY = 1, M_TELE = 2, M_DEAD = 3, M_WIN = 4, M_OVER = 5;
   logic clk = 1'b0, reset_n = 1'b1, tick = 1'b0, start = 1'b0;
   logic [3:0] dir = 4'd0;
   logic startblk = 1'b0, tpblks = 1'b0, lavablks = 1'b0, goalblk = 1'b0;
   logic [9:0] xFlr, yFlr, xCeil, yCeil;
   logic [1:0] lives;
   logic [2:0] state;
   logic win, gameover, frozen;
   maze_player_ctrl dut (
      .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .dir(dir),
      .startblk(startblk), .tpblks(tpblks), .lavablks(lavablks), .goalblk(goalblk),
      .xFlr(xFlr), .yFlr(yFlr), .xCeil(xCeil), .yCeil(yCeil),
      .lives(lives), .state(state), .win(win), .gameover(gameover), .frozen(frozen)
   );
   always #5 clk = ~clk;
   typedef struct packed {
      logic [2:0] st;
      logic [9:0] x, y, xc, yc;
      logic [1:0] lv;
      logic w, g, f;
   } obs_t;
   obs_t q[$];
   int checks = 0, passed = 0;
   int ms, mx, my, ml, marmed, mdead;
   int pad_ox[4] = '{224, 416, 0, 288};
   int pad_oy[4] = '{150, 90, 450, 240};
   function automatic obs_t expect_now();
      obs_t e;
      e.st = 3'(ms);
      e.x  = 10'(mx);
      e.y  = 10'(my);
      e.xc = 10'(mx + 16);
      e.yc = 10'(my + 16);
      e.lv = 2'(ml);
      e.w  = ms == M_WIN;
      e.g  = ms == M_OVER;
      e.f  = ms == M_DEAD;
      return e;
   endfunction
   task automatic m_init();
      mx = 8; my = 7; ml = 3; marmed = 1; mdead = 0;
   endtask
   function automatic int clampi(int v, int hi);
      return v < 0 ? 0 : (v > hi ? hi : v);
   endfunction
   function automatic bit on_pad(int x, int y);
      for (int i = 0; i < 4; i++)
         if (x >= pad_ox[i] && x < pad_ox[i] + 32 && y >= pad_oy[i] && y < pad_oy[i] + 32) return 1'b1;
      return 1'b0;
   endfunction
   task automatic m_step(input logic [3:0] d, input bit tk, input bit st, input bit tp, input bit lava, input bit goal);
      int src, dx, dy;
      case (ms)
         M_IDLE, M_WIN, M_OVER: if (st) begin m_init(); ms = M_PLAY; end
         M_PLAY: begin
            if (!tp) marmed = 1;
            if (goal) ms = M_WIN;
            else if (lava) begin
               ml = ml - 1;
               ms = ml == 0 ? M_OVER : M_DEAD;
               mdead = 0;
            end else if (tp && marmed == 1) ms = M_TELE;
            else if (tk) begin
               dy = d[3] ? -2 : (d[2] ? 2 : 0);
               dx = (d[3] | d[2]) ? 0 : (d[1] ? -2 : (d[0] ? 2 : 0));
               mx = clampi(mx + dx, 624);
               my = clampi(my + dy, 464);
            end
         end
         M_TELE: begin
            src = -1;
            for (int i = 0; i < 4; i++) if (mx >= pad_ox[i] && mx < pad_ox[i] + 32) src = i;
            if (src >= 0) begin
               mx = pad_ox[(src + 1) % 4] + 8;
               my = pad_oy[(src + 1) % 4] + 7;
            end
            marmed = 0;
            ms = M_PLAY;
         end
         M_DEAD: if (tk) begin
            mdead++;
            if (mdead == 32) begin mx = 8; my = 7; marmed = 1; ms = M_PLAY; end
         end
         default: ms = M_IDLE;
      endcase
   endtask
   task automatic step(input logic [3:0] d, input bit tk = 0, input bit st = 0, input bit lava = 0,
                       input bit goal = 0, input bit ftp = 0);
      bit tpf;
      @(negedge clk);
      tpf = ftp || on_pad(mx, my);
      dir = d; tick = tk; start = st; tpblks = tpf; lavablks = lava; goalblk = goal;
      m_step(d, tk, st, tpf, lava, goal);
      q.push_back(expect_now());
   endtask
   task automatic do_reset();
      @(negedge clk);
      #2;
      dir = 4'd0; tick = 1'b0; start = 1'b0; tpblks = 1'b0; lavablks = 1'b0; goalblk = 1'b0;
      ms = M_IDLE;
      m_init();
      q.push_back(expect_now());
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask
   initial begin
      obs_t e, a;
      forever begin
         @(posedge clk or negedge reset_n);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            a = {state, xFlr, yFlr, xCeil, yCeil, lives, win, gameover, frozen};
            checks++;
            if (a === e) passed++;
            else $display("FAIL obs at %0t: got st=%0d x=%0d y=%0d xc=%0d yc=%0d lv=%0d w/g/f=%b%b%b expected st=%0d x=%0d y=%0d xc=%0d yc=%0d lv=%0d w/g/f=%b%b%b",
                          $time, a.st, a.x, a.y, a.xc, a.yc, a.lv, a.w, a.g, a.f, e.st, e.x, e.y, e.xc, e.yc, e.lv, e.w, e.g, e.f);
         end
      end
   end
   initial begin
      ms = M_IDLE;
      m_init();
      do_reset();
      // idle ignores buttons and ticks, then movement and clamping
      repeat (2) step(4'b1111, 1);
      step(4'b0000, 0, 1);
      repeat (10) step(4'b1000, 1);
      repeat (3) step(4'b1010, 1);
      repeat (2) step(4'b0101, 1);
      // walk into pad A, teleport to B, linger, leave and re-enter B to reach C
      do_reset();
      step(4'b0000, 0, 1);
      repeat (112) step(4'b0001, 1);
      for (int i = 0; i < 100 && ms != M_TELE; i++) step(4'b0100, 1);
      step(4'b0000);
      repeat (3) step(4'b0000, 1);
      repeat (4) step(4'b1000, 1);
      for (int i = 0; i < 10 && ms != M_TELE; i++) step(4'b0100, 1);
      step(4'b0000);
      repeat (2) step(4'b0000, 1);
      repeat (6) step(4'b0100, 1);
      repeat (5) step(4'b0010, 1);
      repeat (315) step(4'b0001, 1);
      // lava, dead freeze with start ignored, then game over and restart
      do_reset();
      step(4'b0000, 0, 1);
      step(4'b0000, 0, 0, 1);
      step(4'b0000, 0, 1);
      for (int i = 0; i < 40; i++) step(4'($urandom_range(0, 15)), 1);
      step(4'b0000, 0, 0, 1);
      repeat (33) step(4'b0000, 1);
      step(4'b0000, 0, 0, 1);
      repeat (3) step(4'b1000, 1, 0, 1);
      step(4'b0000, 0, 1);
      // all flags at once: goal wins and lives are kept
      step(4'b0000, 1, 0, 1, 1, 1);
      repeat (2) step(4'b0100, 1, 0, 1, 0, 1);
      step(4'b0000, 0, 1);
      // asynchronous reset during DEAD and during the TELEPORT cycle
      step(4'b0000, 0, 0, 1);
      repeat (10) step(4'b0000, 1);
      do_reset();
      step(4'b0000, 0, 1);
      step(4'b0000, 0, 0, 0, 0, 1);
      do_reset();
      step(4'b0000, 0, 1);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         else step(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0,
                   $urandom_range(0, 59) == 0, $urandom_range(0, 399) == 0, $urandom_range(0, 29) == 0);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (q.size() == 0) passed++;
      else $display("FAIL drain: %0d expectations left, required 0", q.size());
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
